// File: rtl/edge_detect_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one gradient magnitude out per pixel.
// Define EDGE_DETECT_STREAM_THRESH_EN to add the 'thresh' port and binarise interior outputs.
module edge_detect_stream #(
    parameter int IMG_W = 5,
    parameter int IMG_H = 5,
    parameter int PXL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PXL_W-1:0] in_pxl,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PXL_W-1:0] out_pxl,
    output logic             out_sof,
    output logic             out_eof,
    output logic             busy,
    output logic             frame_done,
    output logic             err_sof
`ifdef EDGE_DETECT_STREAM_THRESH_EN
    ,
    input  logic [PXL_W-1:0] thresh
`endif
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = PXL_W + 3;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [XW-1:0]    x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]    y_q, y_d, oy_q, oy_d;
    logic             out_valid_q, out_valid_d;
    logic [PXL_W-1:0] out_pxl_q, out_pxl_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             all_loaded_q, all_loaded_d;
    logic             frame_done_q, frame_done_d;
    logic             err_sof_q, err_sof_d;
    logic [PXL_W-1:0] w00_q, w01_q, w10_q, w11_q, w20_q, w21_q;
    logic [PXL_W-1:0] lb0_q [IMG_W];
    logic [PXL_W-1:0] lb1_q [IMG_W];

    logic             rdy, slot_free, in_acc, pix_take, load, out_hs;
    logic             border, first_idx, last_idx;
    logic [PXL_W-1:0] top_px, mid_px;
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0]    ax, ay;
    logic [PXL_W+3:0] mag;
    logic [PXL_W-1:0] sat, result;

    function automatic logic signed [SW-1:0] ext(input logic [PXL_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    assign slot_free = ~out_valid_q | out_ready;
    assign out_hs    = out_valid_q & out_ready;

    always_comb begin
        case (state_q)
            IDLE, FILL: rdy = 1'b1;
            RUN:        rdy = slot_free;
            default:    rdy = 1'b0;
        endcase
    end

    assign in_ready = rdy & ~rst;
    assign in_acc   = in_valid & in_ready;
    // An sof-less pixel in IDLE is dropped rather than stored.
    assign pix_take = in_acc & ((state_q != IDLE) | in_sof);
    assign load     = ((state_q == RUN) & in_acc) | ((state_q == DRAIN) & slot_free & ~all_loaded_q);

    assign top_px = lb1_q[x_q];
    assign mid_px = lb0_q[x_q];

    assign gx = ext(top_px) + (ext(mid_px) <<< 1) + ext(in_pxl)
              - ext(w00_q) - (ext(w10_q) <<< 1) - ext(w20_q);
    assign gy = ext(w20_q) + (ext(w21_q) <<< 1) + ext(in_pxl)
              - ext(w00_q) - (ext(w01_q) <<< 1) - ext(top_px);
    assign ax  = gx[SW-1] ? -gx : gx;
    assign ay  = gy[SW-1] ? -gy : gy;
    assign mag = {1'b0, ax} + {1'b0, ay};
    assign sat = (|mag[PXL_W+3:PXL_W]) ? {PXL_W{1'b1}} : mag[PXL_W-1:0];

`ifdef EDGE_DETECT_STREAM_THRESH_EN
    logic [PXL_W-1:0] thresh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q <= '0;
        end else if ((state_q == IDLE) && in_acc && in_sof) begin
            thresh_q <= thresh;
        end
    end

    assign result = (sat >= thresh_q) ? {PXL_W{1'b1}} : '0;
`else
    assign result = sat;
`endif

    assign border    = (ox_q == '0) | (oy_q == '0) | (ox_q == X_LAST) | (oy_q == Y_LAST);
    assign first_idx = (ox_q == '0) & (oy_q == '0);
    assign last_idx  = (ox_q == X_LAST) & (oy_q == Y_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_acc && in_sof) state_d = FILL;
            FILL:    if (pix_take && (x_q == '0) && (y_q == YW'(1))) state_d = RUN;
            RUN:     if (pix_take && (x_q == X_LAST) && (y_q == Y_LAST)) state_d = DRAIN;
            DRAIN:   if (out_hs && out_eof_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (pix_take) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        if (load) begin
            if (ox_q == X_LAST) begin
                ox_d = '0;
                oy_d = (oy_q == Y_LAST) ? '0 : oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
    end

    // Output register only changes when empty or being drained, so it holds under back-pressure.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pxl_d    = out_pxl_q;
        out_sof_d    = out_sof_q;
        out_eof_d    = out_eof_q;
        all_loaded_d = all_loaded_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_pxl_d   = border ? '0 : result;
            out_sof_d   = first_idx;
            out_eof_d   = last_idx;
            if (last_idx) all_loaded_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((state_q == DRAIN) && out_hs && out_eof_q) all_loaded_d = 1'b0;
    end

    assign frame_done_d = (state_q == DRAIN) & out_hs & out_eof_q;
    assign err_sof_d    = in_acc & ((state_q == IDLE) ? ~in_sof : in_sof);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            out_valid_q  <= 1'b0;
            out_pxl_q    <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            all_loaded_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
            w00_q        <= '0;
            w01_q        <= '0;
            w10_q        <= '0;
            w11_q        <= '0;
            w20_q        <= '0;
            w21_q        <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            out_valid_q  <= out_valid_d;
            out_pxl_q    <= out_pxl_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            all_loaded_q <= all_loaded_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
            if (pix_take) begin
                w00_q <= w01_q;
                w01_q <= top_px;
                w10_q <= w11_q;
                w11_q <= mid_px;
                w20_q <= w21_q;
                w21_q <= in_pxl;
            end
        end
    end

    // Line buffers hold the two previous rows at the current column; contents need no reset.
    always_ff @(posedge clk) begin
        if (pix_take) begin
            lb1_q[x_q] <= lb0_q[x_q];
            lb0_q[x_q] <= in_pxl;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pxl    = out_pxl_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

endmodule

// File: tb/tb_edge_detect_stream.sv
// Bench for edge_detect_stream: directed and random frames scored against a Sobel reference model.
`timescale 1ns/1ps
module tb_edge_detect_stream;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          out_ready = 1'b1;
    logic [PW-1:0] in_pxl = '0;
    logic          in_ready, out_valid, out_sof, out_eof, busy, frame_done, err_sof;
    logic [PW-1:0] out_pxl;

    int frame [N];
    int outQ [$];
    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int doneCount  = 0;
    int errCount   = 0;

`ifdef EDGE_DETECT_STREAM_THRESH_EN
    int threshVal = 60;
    logic [PW-1:0] thresh;
    assign thresh = threshVal[PW-1:0];
`endif

    edge_detect_stream #(.IMG_W(W), .IMG_H(H), .PXL_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pxl     (in_pxl),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pxl    (out_pxl),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_done (frame_done),
        .err_sof    (err_sof)
`ifdef EDGE_DETECT_STREAM_THRESH_EN
        ,
        .thresh     (thresh)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Sobel straight from its definition: weighted column and row differences, abs, clamp.
    function automatic int refPixel(input int idx);
        int x = idx % W;
        int y = idx / W;
        int gx = 0;
        int gy = 0;
        int mag;
        int wt [3] = '{1, 2, 1};
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 0;
        for (int i = 0; i < 3; i++) begin
            gx += wt[i] * (frame[(y - 1 + i) * W + x + 1] - frame[(y - 1 + i) * W + x - 1]);
            gy += wt[i] * (frame[(y + 1) * W + x - 1 + i] - frame[(y - 1) * W + x - 1 + i]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
`ifdef EDGE_DETECT_STREAM_THRESH_EN
        mag = (mag >= threshVal) ? 255 : 0;
`endif
        return mag;
    endfunction

    function automatic int expWord(input int idx);
        return ((idx == 0) ? 512 : 0) + ((idx == N - 1) ? 256 : 0) + refPixel(idx);
    endfunction

    function automatic int getPxl(input int idx);
        return (idx < outQ.size()) ? (outQ[idx] & 255) : -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one frame; entered and left at posedge+1. Optional 10-cycle stall and extra sof.
    task automatic applyStimulus(input int stallAt, input int extraSofAt, input bit randomFlow);
        int  k = 0;
        int  cyc = 0;
        int  stallLeft = 0;
        bit  stallUsed = 1'b0;
        bit  present = 1'b0;
        bit  accepted;
        outQ.delete();
        doneCount = 0;
        errCount  = 0;
        while (cyc < 600) begin
            if (!present && k < N) present = randomFlow ? ($urandom_range(3) != 0) : 1'b1;
            in_valid = present;
            in_pxl   = present ? frame[k][PW-1:0] : '0;
            in_sof   = present && (k == 0 || k == extraSofAt);
            if (stallLeft > 0) begin
                out_ready = 1'b0;
            end else if (!stallUsed && stallAt >= 0 && outQ.size() == stallAt) begin
                stallUsed = 1'b1;
                stallLeft = 10;
                out_ready = 1'b0;
            end else begin
                out_ready = randomFlow ? ($urandom_range(3) != 0) : 1'b1;
            end
            @(negedge clk);
            if (stallLeft > 0) begin
                checkOutput("stall_valid", 32'(out_valid), 1);
                checkOutput("stall_pxl", 32'(out_pxl), refPixel(stallAt));
                if (stallLeft < 10) checkOutput("stall_in_ready", 32'(in_ready), 0);
                stallLeft--;
            end
            accepted = in_valid && in_ready;
            if (out_valid && out_ready) outQ.push_back(int'({out_sof, out_eof, out_pxl}));
            if (frame_done) doneCount++;
            if (err_sof) errCount++;
            @(posedge clk);
            #1;
            if (accepted) begin
                k++;
                present = 1'b0;
            end
            cyc++;
            if (doneCount > 0 && k == N) break;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic checkFrame(input string name, input int expErr);
        checkOutput({name, "_count"}, outQ.size(), N);
        for (int i = 0; i < N && i < outQ.size(); i++)
            checkOutput($sformatf("%s_out%0d", name, i), outQ[i], expWord(i));
        checkOutput({name, "_done"}, doneCount, 1);
        checkOutput({name, "_err"}, errCount, expErr);
    endtask

    task automatic fillFlat(input int v);
        for (int i = 0; i < N; i++) frame[i] = v;
    endtask

    task automatic fillStep(input int v);
        for (int i = 0; i < N; i++) frame[i] = ((i % W) >= 2) ? v : 0;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(255));
    endtask

    task automatic abortAt(input int stopK);
        int k = 0;
        int cyc = 0;
        bit accepted;
        while (k < stopK && cyc < 200) begin
            in_valid  = 1'b1;
            in_pxl    = frame[k][PW-1:0];
            in_sof    = (k == 0);
            out_ready = 1'b1;
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            if (accepted) k++;
            cyc++;
        end
        checkOutput("abort_reached", k, stopK);
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 0);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_out_pxl", 32'(out_pxl), 0);
        checkOutput("abort_out_sof", 32'(out_sof), 0);
        checkOutput("abort_out_eof", 32'(out_eof), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_frame_done", 32'(frame_done), 0);
        checkOutput("abort_err_sof", 32'(err_sof), 0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_abort_busy", 32'(busy), 0);
        checkOutput("post_abort_valid", 32'(out_valid), 0);
        checkOutput("post_abort_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] edge_detect_stream bench start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 1);
        checkOutput("idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        fillFlat(100);
        applyStimulus(-1, -1, 1'b0);
        checkFrame("flat", 0);

        fillFlat(0);
        for (int i = 0; i < W; i++) frame[i * W + i] = 250 + i;
        applyStimulus(-1, -1, 1'b0);
        checkFrame("diag", 0);
`ifndef EDGE_DETECT_STREAM_THRESH_EN
        checkOutput("diag_11", getPxl(6), 4);
`endif

        fillStep(200);
        applyStimulus(-1, -1, 1'b0);
        checkFrame("step200", 0);
`ifndef EDGE_DETECT_STREAM_THRESH_EN
        checkOutput("step200_11", getPxl(6), 255);
        checkOutput("step200_21", getPxl(7), 255);
        checkOutput("step200_31", getPxl(8), 0);
`endif

        fillStep(10);
        applyStimulus(-1, -1, 1'b0);
        checkFrame("step10", 0);
`ifndef EDGE_DETECT_STREAM_THRESH_EN
        checkOutput("step10_11", getPxl(6), 40);
`else
        threshVal = 41;
        applyStimulus(-1, -1, 1'b0);
        checkFrame("thr41", 0);
        checkOutput("thr41_11", getPxl(6), 0);
        threshVal = 40;
        applyStimulus(-1, -1, 1'b0);
        checkFrame("thr40", 0);
        checkOutput("thr40_11", getPxl(6), 255);
        threshVal = 60;
`endif

        fillRandom();
        applyStimulus(-1, -1, 1'b0);
        checkFrame("rand", 0);
        applyStimulus(8, -1, 1'b0);
        checkFrame("backpressure", 0);

        for (int f = 0; f < 3; f++) begin
            fillRandom();
            applyStimulus(-1, -1, 1'b1);
            checkFrame($sformatf("randflow%0d", f), 0);
        end

        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_pxl   = 8'd77;
        @(negedge clk);
        checkOutput("nosof_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("nosof_err", 32'(err_sof), 1);
        checkOutput("nosof_busy", 32'(busy), 0);
        checkOutput("nosof_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("nosof_err_pulse", 32'(err_sof), 0);
        @(posedge clk);
        #1;

        fillRandom();
        applyStimulus(-1, 7, 1'b0);
        checkFrame("midsof", 1);

        fillRandom();
        abortAt(12);
        fillRandom();
        applyStimulus(-1, -1, 1'b0);
        checkFrame("after_abort", 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/edge_detect_stream.md
Name: edge_detect_stream

Overview:
Parametrised streaming 3x3 Sobel edge detector, the successor to the frame-buffer-based edge detector top. It accepts raster-order pixels over a valid/ready stream with start-of-frame marking and emits one gradient-magnitude pixel per input pixel, with back-pressure. Two internal line buffers replace the full input frame buffer, so any IMG_W x IMG_H frame is supported. It sits between the pixel source and the output frame buffer or downstream stream sink.

Parameters:
IMG_W, 5, frame width in pixels (>=3)
IMG_H, 5, frame height in pixels (>=3)
PXL_W, 8, pixel width in bits, unsigned grey level

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts input this cycle
in_pxl  in  PXL_W  input pixel
in_sof  in  1  marks pixel (0,0) of a frame
out_valid  out  1  output pixel valid
out_ready  in  1  sink accepts output
out_pxl  out  PXL_W  gradient magnitude
out_sof  out  1  marks output (0,0)
out_eof  out  1  marks output (IMG_W-1,IMG_H-1)
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  1-cycle pulse on the cycle after the eof output handshake
err_sof  out  1  1-cycle pulse on a protocol error

Behaviour:
- Clock is clk; reset is asynchronous, active-high, port rst. While rst is high, all outputs are 0: in_ready, out_valid, out_pxl, out_sof, out_eof, busy, frame_done, err_sof. Counters, state and window are cleared. Line-buffer contents are don't-care.
- Reset mid-frame discards the frame with no outputs. After release, the block is in IDLE.
- Transfers occur on clk when valid && ready. out_pxl, out_sof and out_eof hold stable while out_valid && !out_ready.
- FSM states are IDLE, FILL, RUN and DRAIN. Raster index k = y*IMG_W+x. N = IMG_W*IMG_H.
- IDLE: in_ready=1. A pixel accepted with in_sof=1 becomes k=0 and the FSM goes to FILL. A pixel accepted without in_sof is dropped and err_sof pulses.
- FILL: in_ready=1 and no outputs are produced. After pixel k=IMG_W has been accepted, the FSM goes to RUN.
- RUN: in_ready = !out_valid || out_ready. Accepting input k (k>=IMG_W+1) loads output index k-IMG_W-1 into the output register, so out_valid is asserted on the next cycle. After k=N-1 is accepted, the FSM goes to DRAIN.
- DRAIN: in_ready=0. The block emits the remaining IMG_W+1 outputs, all of which are border pixels and therefore 0, one per out_valid && out_ready. After the eof handshake, frame_done pulses and the FSM returns to IDLE.
- An in_sof accepted mid-frame (k!=0) is ignored: the pixel is processed normally and err_sof pulses.
- Border outputs (x=0, y=0, x=IMG_W-1, y=IMG_H-1) are forced to 0.
- Interior outputs use window p[r][c], r,c in 0..2, centred on (x,y):
  Gx = (p02+2p12+p22) - (p00+2p10+p20)
  Gy = (p20+2p21+p22) - (p00+2p01+p02)
  Both are signed, PXL_W+3 bits. mag = |Gx|+|Gy|, PXL_W+4 bits, saturated to 2^PXL_W-1.
- out_sof is asserted with output index 0. out_eof is asserted with output index N-1.
- Throughput is one pixel per cycle with out_ready held high. End-to-end latency is IMG_W+1 accepted pixels plus one cycle.
- frame_done and err_sof may pulse in the same cycle. A new in_sof is accepted in IDLE the cycle after frame_done.

Optional Feature:
Macro EDGE_DETECT_STREAM_THRESH_EN.
- Defined: adds input port thresh [PXL_W] and binarises the result. An interior output is 2^PXL_W-1 if saturated mag >= thresh, else 0. Border outputs stay 0. thresh is sampled once per frame, on the in_sof accept.
- Undefined: the port is absent and the raw saturated magnitude is output.

Test Plan:
- Defaults, flat frame of 25 pixels all 100, out_ready=1 -> 25 outputs all 0; out_sof on the 1st output, out_eof on the 25th; frame_done pulses once.
- Diagonal frame: (0,0)=250, (1,1)=251, (2,2)=252, (3,3)=253, (4,4)=254, all others 0 -> output (1,1)=4, (2,1)=251+...: bench compares every pixel to a reference model; all borders 0.
- Vertical step: columns 0-1=0, columns 2-4=200 -> row 1: (1,1)=255 (mag 800 saturated), (2,1)=255, (3,1)=0; a step of 10 instead of 200 gives (1,1)=40.
- Back-pressure: out_ready low for 10 cycles at output index 8 -> in_ready low from the next cycle, out_pxl stable, no loss or duplication; the 25 outputs match the out_ready=1 run.
- Protocol: a pixel without in_sof in IDLE -> dropped, err_sof 1 cycle, no output; in_sof on k=7 -> err_sof pulse, frame completes with 25 outputs.
- rst asserted at input k=12 -> all outputs 0 immediately; the next full frame after release produces correct 25 outputs. With EDGE_DETECT_STREAM_THRESH_EN and thresh=41, the step-of-10 frame gives (1,1)=0; with thresh=40 it gives 255.
